// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master processor bus arbiter.
package bus_arb_pkg;
  localparam int         NUM_MASTERS   = 2;
  localparam logic [7:0] IDLE_ADDR_DEF = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    TURN
  } state_e;
endpackage

// File: rtl/bus_arb_grant.sv
// Winner selection for the bus arbiter: round-robin with a hold limit, or
// fixed priority to master 0 when BUS_ARB_FIXED_PRI_EN is defined.
module bus_arb_grant
  import bus_arb_pkg::*;
#(
  parameter int HOLD_LIMIT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [NUM_MASTERS-1:0] done_i,
  input  logic                   grant_i,
  output logic [NUM_MASTERS-1:0] win_o
);
  logic [NUM_MASTERS-1:0] req_eff;

  // A master is not eligible in its own DONE cycle.
  assign req_eff = req_i & ~done_i;

`ifdef BUS_ARB_FIXED_PRI_EN
  logic unused_fp;
  assign unused_fp = ^{clk, rst_n, grant_i};

  always_comb begin
    win_o = '0;
    if (req_eff[0])      win_o = 2'b01;
    else if (req_eff[1]) win_o = 2'b10;
  end
`else
  localparam int            HW       = $clog2(HOLD_LIMIT + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_LIMIT);

  logic          ptr_q, ptr_d, win_idx;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    win_idx = ptr_q;
    case (req_eff)
      2'b01:   win_idx = 1'b0;
      2'b10:   win_idx = 1'b1;
      // Zero hold count only exists after reset: the master after the pointer goes first.
      2'b11:   win_idx = (hold_q != '0 && hold_q < HOLD_LIM) ? ptr_q : ~ptr_q;
      default: win_idx = ptr_q;
    endcase
    win_o  = (req_eff == '0) ? '0 : (win_idx ? 2'b10 : 2'b01);
    ptr_d  = ptr_q;
    hold_d = hold_q;
    if (grant_i && req_eff != '0) begin
      ptr_d = win_idx;
      if (win_idx != ptr_q)    hold_d = HW'(1);
      else if (req_eff == 2'b11) hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= 1'b1;
      hold_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
    end
  end
`endif
endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter sequencing single-byte accesses on the shared 8-bit bus.
// Fixed-priority arbitration is selected with BUS_ARB_FIXED_PRI_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int         HOLD_LIMIT = 2,
  parameter logic [7:0] IDLE_ADDR  = IDLE_ADDR_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_MASTERS-1:0]   REQ,
  input  logic [8*NUM_MASTERS-1:0] ADDR,
  input  logic [NUM_MASTERS-1:0]   WE,
  input  logic [8*NUM_MASTERS-1:0] WDATA,
  output logic [NUM_MASTERS-1:0]   GNT,
  output logic [NUM_MASTERS-1:0]   DONE,
  output logic [8*NUM_MASTERS-1:0] RDATA,
  output logic [7:0]               BUS_ADDR,
  output logic                     BUS_WE,
  inout  wire  [7:0]               BUS_DATA
);
  state_e                   state_q;
  logic [NUM_MASTERS-1:0]   gnt_q, done_q, win;
  logic [8*NUM_MASTERS-1:0] rdata_q;
  logic [7:0]               bus_addr_q, wdata_q, addr_sel, wdata_sel;
  logic                     bus_we_q, drv_q, we_sel;

  bus_arb_grant #(.HOLD_LIMIT(HOLD_LIMIT)) u_grant (
    .clk     (CLK),
    .rst_n   (RESET),
    .req_i   (REQ),
    .done_i  (done_q),
    .grant_i (state_q == IDLE),
    .win_o   (win)
  );

  assign addr_sel  = win[1] ? ADDR[15:8]  : ADDR[7:0];
  assign wdata_sel = win[1] ? WDATA[15:8] : WDATA[7:0];
  assign we_sel    = win[1] ? WE[1]       : WE[0];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      bus_addr_q <= IDLE_ADDR;
      bus_we_q   <= 1'b0;
      drv_q      <= 1'b0;
      wdata_q    <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: if (win != '0) begin
          gnt_q      <= win;
          bus_addr_q <= addr_sel;
          wdata_q    <= wdata_sel;
          bus_we_q   <= we_sel;
          drv_q      <= we_sel;
          state_q    <= we_sel ? WR : RD_ADDR;
        end
        WR: begin
          done_q     <= gnt_q;
          gnt_q      <= '0;
          bus_addr_q <= IDLE_ADDR;
          bus_we_q   <= 1'b0;
          drv_q      <= 1'b0;
          state_q    <= IDLE;
        end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          for (int i = 0; i < NUM_MASTERS; i++)
            if (gnt_q[i]) rdata_q[8*i +: 8] <= BUS_DATA;
          done_q     <= gnt_q;
          gnt_q      <= '0;
          bus_addr_q <= IDLE_ADDR;
          state_q    <= TURN;
        end
        // Slave still drives during TURN; the arbiter stays off the bus.
        TURN:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign RDATA    = rdata_q;
  assign BUS_ADDR = bus_addr_q;
  assign BUS_WE   = bus_we_q;
  assign BUS_DATA = drv_q ? wdata_q : {8{1'bz}};
endmodule
